// File: rtl/if_pkg.sv
// if_pkg
// Shared definitions for the instruction fetch queue: default parameter
// values and the queue entry layout {pc, instr}. if_entry_t is sized for the
// default widths; the RTL carries entries as flat vectors so that other
// widths remain usable.
package if_pkg;

    localparam int ADDR_W_DEF   = 32;
    localparam int INSTR_W_DEF  = 32;
    localparam int DEPTH_DEF    = 4;
    localparam int RESET_PC_DEF = 0;
    localparam int PC_STEP_DEF  = 4;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0]  pc;
        logic [INSTR_W_DEF-1:0] instr;
    } if_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
// Flop-array FIFO holding fetched entries, with synchronous flush and
// asynchronous active-high reset.
// Ports:
//   clk, rst        clock, async active-high reset
//   flush           empty the queue at the edge (takes priority)
//   push, wdata     write wdata at the tail
//   pop             drop the head entry
//   rdata           head entry (combinational from the array)
//   count           occupied entries, 0..DEPTH
module fetch_fifo
    import if_pkg::*;
#(
    parameter int WIDTH = $bits(if_entry_t),
    parameter int DEPTH = DEPTH_DEF,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [PW-1:0]               head_q, head_d;
    logic [PW-1:0]               tail_q, tail_d;
    logic [CW-1:0]               count_q, count_d;
    logic                        push_ok;
    logic                        pop_ok;

    // Guard locally so count can never leave 0..DEPTH whatever the caller does.
    // Push on a full queue is only accepted when a pop frees the head slot.
    assign pop_ok  = pop && (count_q != '0);
    assign push_ok = push && ((count_q < CW'(DEPTH)) || pop_ok);

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[tail_q] = wdata;
                tail_d        = tail_q + PW'(1);
            end
            if (pop_ok) begin
                head_d = head_q + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // The array is reset too so the head outputs are never X after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign rdata = mem_q[head_q];
    assign count = count_q;

endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue
// Instruction fetch unit with a small decoupling queue. Each cycle the
// memory returns data for imem_addr, the fetched entry {pc+step, instr} is
// queued and the fetch address advances; decode drains the head with a
// valid/ready handshake. A taken branch flushes the queue and redirects
// fetch.
// Ports:
//   clk, rst                   clock, async active-high reset
//   Branch_taken, BranchAddr   redirect request and target
//   imem_addr                  fetch address (registered fetch_pc)
//   imem_data, imem_ready      memory read data for imem_addr, valid flag
//   out_valid, out_ready       head handshake toward decode
//   PC, Instruction            head entry (fetch address + PC_STEP, instr)
//   count                      occupied queue entries
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int INSTR_W  = INSTR_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int RESET_PC = RESET_PC_DEF,
    parameter int PC_STEP  = PC_STEP_DEF,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Branch_taken,
    input  logic [ADDR_W-1:0]  BranchAddr,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               imem_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  PC,
    output logic [INSTR_W-1:0] Instruction,
    output logic [CW-1:0]      count
);

    localparam int EW = ADDR_W + INSTR_W;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] next_pc;
    logic              push;
    logic              pop;
    logic [EW-1:0]     wdata;
    logic [EW-1:0]     rdata;

    assign next_pc   = fetch_pc_q + ADDR_W'(PC_STEP);
    assign imem_addr = fetch_pc_q;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign push      = imem_ready && !Branch_taken && ((count < CW'(DEPTH)) || pop);
    assign wdata     = {next_pc, imem_data};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (Branch_taken) begin
            fetch_pc_d = BranchAddr;
        end else if (push) begin
            fetch_pc_d = next_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= ADDR_W'(RESET_PC);
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // A pop in a branch cycle is swallowed by the flush; the consumer still
    // takes the head it saw, which has no effect on the queue.
    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (Branch_taken),
        .push  (push),
        .pop   (pop && !Branch_taken),
        .wdata (wdata),
        .rdata (rdata),
        .count (count)
    );

    assign {PC, Instruction} = rdata;

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;
    import if_pkg::*;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        Branch_taken;
    logic [31:0] BranchAddr;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    if_entry_t   mq[$];
    logic [31:0] mpc;

    if_fetch_queue dut (
        .clk          (clk),
        .rst          (rst),
        .Branch_taken (Branch_taken),
        .BranchAddr   (BranchAddr),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .imem_ready   (imem_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .PC           (PC),
        .Instruction  (Instruction),
        .count        (count)
    );

    assign imem_data = imem_addr ^ KEY;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: queue of {pc, instr} plus the fetch address.
    task automatic model_step();
        bit        pop_m, push_m;
        if_entry_t e, d;
        pop_m  = (mq.size() != 0) && out_ready;
        push_m = imem_ready && !Branch_taken && ((mq.size() < 4) || pop_m);
        if (Branch_taken) begin
            mq.delete();
            mpc = BranchAddr;
        end else begin
            if (pop_m) d = mq.pop_front();
            if (push_m) begin
                e.pc    = mpc + 32'd4;
                e.instr = mpc ^ KEY;
                mq.push_back(e);
                mpc = mpc + 32'd4;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        Branch_taken = 1'b0;
        BranchAddr   = '0;
        imem_ready   = 1'b0;
        out_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        mq.delete();
        mpc = 32'd0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_checks++; if (imem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        rst = 1'b0;
        #1;
        n_checks++; if ((^{PC, Instruction}) === 1'bx) begin n_fail++; $display("FAIL reset_noX: got PC=%h I=%h want no X", PC, Instruction); end
        imem_ready = 1'b1;
        out_ready  = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL no_bypass: got valid %b want 0", out_valid); end
        cycle();
        n_checks++; if (out_valid !== 1'b1 || PC !== 32'd4 || Instruction !== KEY) begin
            n_fail++; $display("FAIL first_push: got v=%b PC=%h I=%h want v=1 PC=4 I=%h", out_valid, PC, Instruction, KEY);
        end
    endtask

    task automatic test_stream();
        do_reset();
        imem_ready = 1'b1;
        out_ready  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            n_checks++; if (out_valid !== 1'b1 || PC !== 32'(4 * (i + 1)) || Instruction !== (32'(4 * i) ^ KEY)) begin
                n_fail++; $display("FAIL stream[%0d]: got v=%b PC=%h I=%h want PC=%h", i, out_valid, PC, Instruction, 32'(4 * (i + 1)));
            end
            n_checks++; if (count !== 3'(mq.size()) || imem_addr !== mpc) begin
                n_fail++; $display("FAIL stream_state[%0d]: got cnt=%0d addr=%h want cnt=%0d addr=%h", i, count, imem_addr, mq.size(), mpc);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        imem_ready = 1'b1;
        out_ready  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            n_checks++; if (count !== 3'(mq.size()) || imem_addr !== mpc) begin
                n_fail++; $display("FAIL stall[%0d]: got cnt=%0d addr=%h want cnt=%0d addr=%h", i, count, imem_addr, mq.size(), mpc);
            end
        end
        n_checks++; if (count !== 3'd4 || imem_addr !== 32'd16) begin
            n_fail++; $display("FAIL stall_sat: got cnt=%0d addr=%h want cnt=4 addr=10", count, imem_addr);
        end
        imem_ready = 1'b0;
        out_ready  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (out_valid !== 1'b1 || PC !== 32'(4 * (k + 1)) || Instruction !== (32'(4 * k) ^ KEY)) begin
                n_fail++; $display("FAIL drain[%0d]: got v=%b PC=%h want PC=%h", k, out_valid, PC, 32'(4 * (k + 1)));
            end
            cycle();
        end
        n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_empty: got cnt=%0d v=%b want 0/0", count, out_valid);
        end
    endtask

    task automatic test_full_stream();
        logic [31:0] prev;
        imem_ready = 1'b1;
        out_ready  = 1'b0;
        repeat (4) cycle();
        out_ready = 1'b1;
        prev = PC;
        for (int i = 0; i < 20; i++) begin
            cycle();
            n_checks++; if (count !== 3'd4 || PC !== prev + 32'd4) begin
                n_fail++; $display("FAIL full_stream[%0d]: got cnt=%0d PC=%h want cnt=4 PC=%h", i, count, PC, prev + 32'd4);
            end
            n_checks++; if (PC !== mq[0].pc || Instruction !== mq[0].instr || imem_addr !== mpc) begin
                n_fail++; $display("FAIL full_model[%0d]: got PC=%h I=%h addr=%h want PC=%h I=%h addr=%h", i, PC, Instruction, imem_addr, mq[0].pc, mq[0].instr, mpc);
            end
            prev = PC;
        end
    endtask

    task automatic test_branch();
        do_reset();
        imem_ready = 1'b1;
        out_ready  = 1'b0;
        repeat (3) cycle();
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL br_pre: got cnt=%0d want 3", count); end
        Branch_taken = 1'b1;
        BranchAddr   = 32'h100;
        out_ready    = 1'b1;
        cycle();
        Branch_taken = 1'b0;
        n_checks++; if (count !== 3'd0 || out_valid !== 1'b0 || imem_addr !== 32'h100) begin
            n_fail++; $display("FAIL br_flush: got cnt=%0d v=%b addr=%h want 0/0/100", count, out_valid, imem_addr);
        end
        cycle();
        n_checks++; if (out_valid !== 1'b1 || PC !== 32'h104 || Instruction !== (32'h100 ^ KEY)) begin
            n_fail++; $display("FAIL br_target: got v=%b PC=%h I=%h want PC=104", out_valid, PC, Instruction);
        end
        for (int i = 0; i < 6; i++) begin
            cycle();
            n_checks++; if (out_valid !== 1'b1 || PC !== 32'(32'h108 + 4 * i) || count !== 3'(mq.size())) begin
                n_fail++; $display("FAIL br_seq[%0d]: got PC=%h cnt=%0d want PC=%h", i, PC, count, 32'(32'h108 + 4 * i));
            end
        end
    endtask

    task automatic test_imem_toggle();
        int nready;
        do_reset();
        out_ready = 1'b1;
        nready    = 0;
        for (int i = 0; i < 12; i++) begin
            imem_ready = (i % 2 == 0);
            if (i % 2 == 0) nready++;
            cycle();
            n_checks++; if (imem_addr !== 32'(4 * nready)) begin
                n_fail++; $display("FAIL toggle_addr[%0d]: got %h want %h", i, imem_addr, 32'(4 * nready));
            end
            n_checks++; if (out_valid !== (mq.size() != 0) || (mq.size() != 0 && PC !== mq[0].pc)) begin
                n_fail++; $display("FAIL toggle_head[%0d]: got v=%b PC=%h want v=%b", i, out_valid, PC, mq.size() != 0);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        imem_ready = 1'b1;
        out_ready  = 1'b0;
        repeat (2) cycle();
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL arst_pre: got cnt=%0d want 2", count); end
        #3;
        rst = 1'b1;
        #1;
        n_checks++; if (count !== 3'd0 || out_valid !== 1'b0 || imem_addr !== 32'd0) begin
            n_fail++; $display("FAIL arst_now: got cnt=%0d v=%b addr=%h want 0/0/0", count, out_valid, imem_addr);
        end
        #1;
        rst = 1'b0;
        mq.delete();
        mpc = 32'd0;
        cycle();
        n_checks++; if (count !== 3'd1 || PC !== 32'd4 || imem_addr !== 32'd4) begin
            n_fail++; $display("FAIL arst_restart: got cnt=%0d PC=%h addr=%h want 1/4/4", count, PC, imem_addr);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            Branch_taken = ($urandom_range(0, 15) == 0);
            BranchAddr   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'hFFFF_FFFC);
            imem_ready   = ($urandom_range(0, 3) != 0);
            out_ready    = ($urandom_range(0, 1) == 1);
            cycle();
            n_checks++; if (count !== 3'(mq.size()) || count > 3'd4) begin
                n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, count, mq.size());
            end
            n_checks++; if (imem_addr !== mpc) begin
                n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, imem_addr, mpc);
            end
            n_checks++; if (out_valid !== (mq.size() != 0)) begin
                n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, out_valid, mq.size() != 0);
            end
            if (mq.size() != 0) begin
                n_checks++; if (PC !== mq[0].pc || Instruction !== mq[0].instr) begin
                    n_fail++; $display("FAIL rnd_head[%0d]: got PC=%h I=%h want PC=%h I=%h", i, PC, Instruction, mq[0].pc, mq[0].instr);
                end
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        Branch_taken = 1'b0;
        BranchAddr   = '0;
        imem_ready   = 1'b0;
        out_ready    = 1'b0;
        mpc          = 32'd0;
        test_reset();
        test_stream();
        test_stall();
        test_full_stream();
        test_branch();
        test_imem_toggle();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning PC and branch address width.
REQ-002 The block SHALL have parameter INSTR_W, default 32, meaning instruction width.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning fetch queue entries; it must be a power of two and at least 2.
REQ-004 The block SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-005 The block SHALL have parameter PC_STEP, default 4, meaning the fetch address increment.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port Branch_taken, input, 1 bit: redirect fetch and flush the queue.
REQ-009 The block SHALL have port BranchAddr, input, ADDR_W bits: redirect target.
REQ-010 The block SHALL have port imem_addr, output, ADDR_W bits: current fetch address.
REQ-011 The block SHALL have port imem_data, input, INSTR_W bits: combinational memory read data for imem_addr.
REQ-012 The block SHALL have port imem_ready, input, 1 bit: imem_data is valid this cycle.
REQ-013 The block SHALL have port out_valid, output, 1 bit: queue head is valid.
REQ-014 The block SHALL have port out_ready, input, 1 bit: the decode stage accepts the head; this replaces freeze.
REQ-015 The block SHALL have port PC, output, ADDR_W bits: head fetch address + PC_STEP.
REQ-016 The block SHALL have port Instruction, output, INSTR_W bits: head instruction.
REQ-017 The block SHALL have port count, output, $clog2(DEPTH+1) bits: occupied entries.

Function
REQ-018 fetch_pc SHALL be a register, and imem_addr SHALL equal fetch_pc combinationally.
REQ-019 pop SHALL be out_valid && out_ready; out_valid SHALL be (count != 0).
REQ-020 push SHALL be imem_ready && !Branch_taken && (count < DEPTH || pop).
REQ-021 On push, the entry {fetch_pc + PC_STEP, imem_data} SHALL be written at the tail, and fetch_pc SHALL advance by PC_STEP at the same edge.
REQ-022 When push is 0 and Branch_taken is 0, fetch_pc SHALL hold.
REQ-023 PC and Instruction SHALL come from the head entry; when out_valid is 0 their values are don't-care, but they SHALL not be X after reset, and the bench SHALL check them only when valid.
REQ-024 Latency SHALL be one cycle: an instruction pushed at edge N SHALL be visible at the head after edge N when the queue was empty; there is no bypass path from imem_data to the outputs.
REQ-025 Simultaneous push and pop SHALL leave count unchanged, and SHALL be legal when full.
REQ-026 When full and not popping, push SHALL be 0 and fetch_pc SHALL hold; no entry SHALL be overwritten.
REQ-027 Branch_taken SHALL have priority over all other events: at the edge, count becomes 0, fetch_pc becomes BranchAddr, no push occurs, and any pop in that cycle is discarded (the head is still consumed by the consumer, with no side effect).
REQ-028 After a branch, the first instruction from BranchAddr SHALL reach out_valid one cycle later, given imem_ready.
REQ-029 Head and tail pointers SHALL be $clog2(DEPTH) bits and SHALL wrap modulo DEPTH; PC arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-030 count SHALL never exceed DEPTH nor underflow.

Reset
REQ-031 While rst is high, asynchronously: fetch_pc = RESET_PC, pointers = 0, count = 0, out_valid = 0.
REQ-032 Reset asserted mid-operation SHALL discard all queued entries immediately, with no output pulse.
REQ-033 The first push SHALL occur on the first rising edge after rst deasserts, when imem_ready = 1.

Structure
REQ-034 The default parameter values and an if_entry_t typedef {pc, instr} SHALL live in shared package if_pkg.
REQ-035 The storage SHALL be one sub-module, fetch_fifo: parametrised, with flush, push, pop, count, and asynchronous reset.
REQ-036 Storage SHALL be a flop array; the synthesizable body SHALL use no memory macros.

Verification
REQ-037 Reset, then imem_ready=1 and out_ready=1 with imem returning addr^32'hA5A5_0000 -> out_valid rises in cycle 1; the PC sequence is 4, 8, 12, ...; Instruction matches.
REQ-038 out_ready=0 for 10 cycles with DEPTH=4 -> count saturates at 4, imem_addr holds at 16, and the first four entries are later popped in order with PC 4, 8, 12, 16.
REQ-039 Queue full and out_ready=1 continuously -> one push and one pop per cycle, count stays 4, no lost or duplicated PC.
REQ-040 Branch_taken=1, BranchAddr=32'h100 while count=3 and popping -> count becomes 0, then the next head has PC 32'h104 and no stale entries appear.
REQ-041 imem_ready toggling 1,0,1,0 -> only the ready cycles advance fetch_pc, and the PC sequence has no gaps.
REQ-042 rst pulsed asynchronously between edges with count=2 -> count=0 and out_valid=0 immediately; fetch restarts at RESET_PC.
